// File: rtl/iir1_ctrl.sv
// iir1_ctrl: first-order Q16.16 IIR sequencer over a shared adder/multiplier.
// IIR1_SAT_EN: saturate adder results on signed overflow.
module iir1_ctrl #(
  parameter logic [31:0] A1 = 32'h0000_8000,
  parameter logic [31:0] B0 = 32'h0002_0000,
  parameter logic [31:0] B1 = 32'h0003_0000,
  parameter logic [31:0] W0 = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic [31:0] x,
  input  logic        x_valid,
  output logic        x_ready,
  output logic [31:0] y,
  output logic        y_valid,
  input  logic        y_ready,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_p,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  input  logic [31:0] add_sum,
  output logic [31:0] w_q,
  output logic        busy,
  output logic        ovf_sticky
);

  typedef enum logic [2:0] {
    IDLE, MA1, SUB, MB0, MB1, ADD, OUT
  } state_t;

  state_t      state;
  logic [31:0] x_reg;
  logic [31:0] p_reg;
  logic [31:0] t_reg;
  logic [31:0] wn_reg;
  logic [31:0] w;
  logic [31:0] y_reg;
  logic        ovf;
  logic [31:0] add_res;

  assign x_ready = (state == IDLE) && !clear;
  assign y_valid = (state == OUT);
  assign busy    = (state != IDLE);
  assign y       = y_reg;
  assign w_q     = w;

  // Operand routing: one arithmetic operation per sequencing state
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    add_a = '0;
    add_b = '0;
    unique case (state)
      MA1: begin
        mul_a = A1;
        mul_b = w;
      end
      SUB: begin
        add_a = x_reg;
        add_b = ~p_reg + 32'd1;
      end
      MB0: begin
        mul_a = B0;
        mul_b = wn_reg;
      end
      MB1: begin
        mul_a = B1;
        mul_b = w;
      end
      ADD: begin
        add_a = p_reg;
        add_b = t_reg;
      end
      default: ;
    endcase
  end

  // Signed overflow detection and optional saturation of the adder result
  always_comb begin
    ovf = ((state == SUB) || (state == ADD)) &&
          (add_a[31] == add_b[31]) &&
          (add_sum[31] != add_a[31]);
`ifdef IIR1_SAT_EN
    if (ovf)
      add_res = add_a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else
      add_res = add_sum;
`else
    add_res = add_sum;
`endif
  end

  // Sequencer FSM with filter state, pipeline registers and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      x_reg      <= '0;
      p_reg      <= '0;
      t_reg      <= '0;
      wn_reg     <= '0;
      w          <= W0;
      y_reg      <= '0;
      ovf_sticky <= 1'b0;
    end else if (clear) begin
      state      <= IDLE;
      w          <= W0;
      ovf_sticky <= 1'b0;
    end else begin
      ovf_sticky <= ovf_sticky | ovf;
      unique case (state)
        IDLE: begin
          if (x_valid) begin
            x_reg <= x;
            state <= MA1;
          end
        end
        MA1: begin
          p_reg <= mul_p;
          state <= SUB;
        end
        SUB: begin
          wn_reg <= add_res;
          state  <= MB0;
        end
        MB0: begin
          p_reg <= mul_p;
          state <= MB1;
        end
        MB1: begin
          t_reg <= mul_p;
          state <= ADD;
        end
        ADD: begin
          y_reg <= add_res;
          w     <= wn_reg;
          state <= OUT;
        end
        OUT: begin
          if (y_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iir1_ctrl.sv
// tb_iir1_ctrl: directed checks of iir1_ctrl with behavioural adder/multiplier.
// Second instance uses W0 = 0x8000_0000 for the overflow case.
module tb_iir1_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic [31:0] x;
  logic        x_valid;
  logic        y_ready;

  logic        x_ready, y_valid, busy, ovf_sticky;
  logic [31:0] y, w_q, mul_a, mul_b, mul_p, add_a, add_b, add_sum;

  logic        x_ready2, y_valid2, busy2, ovf_sticky2;
  logic [31:0] y2, w_q2, mul_a2, mul_b2, mul_p2, add_a2, add_b2, add_sum2;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] qmul(input logic [31:0] a,
                                       input logic [31:0] b);
    logic signed [63:0] pr;
    pr = 64'($signed(a)) * 64'($signed(b));
    return pr[47:16];
  endfunction

  assign mul_p    = qmul(mul_a, mul_b);
  assign add_sum  = add_a + add_b;
  assign mul_p2   = qmul(mul_a2, mul_b2);
  assign add_sum2 = add_a2 + add_b2;

  iir1_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .x(x), .x_valid(x_valid), .x_ready(x_ready),
    .y(y), .y_valid(y_valid), .y_ready(y_ready),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .w_q(w_q), .busy(busy), .ovf_sticky(ovf_sticky)
  );

  iir1_ctrl #(.W0(32'h8000_0000)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .x(x), .x_valid(x_valid), .x_ready(x_ready2),
    .y(y2), .y_valid(y_valid2), .y_ready(y_ready),
    .mul_a(mul_a2), .mul_b(mul_b2), .mul_p(mul_p2),
    .add_a(add_a2), .add_b(add_b2), .add_sum(add_sum2),
    .w_q(w_q2), .busy(busy2), .ovf_sticky(ovf_sticky2)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Offer one sample, leave y_ready low, return once y_valid rises.
  task automatic send(input logic [31:0] v);
    int lat;
    @(negedge clk);
    check("x_ready_pre", 32'(x_ready), 32'd1);
    x = v;
    x_valid = 1'b1;
    y_ready = 1'b0;
    @(posedge clk);
    #1 x_valid = 1'b0;
    lat = 0;
    while (!y_valid && lat < 12) begin
      @(posedge clk);
      #1 lat++;
    end
    check("latency", 32'(lat), 32'd5);
  endtask

  task automatic release_y();
    @(negedge clk);
    x_valid = 1'b0;
    y_ready = 1'b1;
    @(posedge clk);
    #1 y_ready = 1'b0;
    check("rel_busy", 32'(busy), 32'd0);
    check("rel_yv", 32'(y_valid), 32'd0);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
  endtask

  logic [31:0] w_exp2;

  initial begin
    rst_n   = 1'b0;
    clear   = 1'b0;
    x       = '0;
    x_valid = 1'b0;
    y_ready = 1'b0;
    #12;
    check("rst_yv", 32'(y_valid), 32'd0);
    check("rst_y", y, 32'h0);
    check("rst_w", w_q, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(ovf_sticky), 32'd0);
    check("rst_w2", w_q2, 32'h8000_0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("x_ready_idle", 32'(x_ready), 32'd1);
    clear = 1'b1;
    #1 check("x_ready_clr", 32'(x_ready), 32'd0);
    clear = 1'b0;

    // Step response: w=0, x=1.0
    send(32'h0001_0000);
    check("s1_y", y, 32'h0002_0000);
    check("s1_w", w_q, 32'h0001_0000);
    release_y();

    // x=0 with w=1.0: wn=-0.5, y=2*-0.5+3*1.0
    send(32'h0000_0000);
    check("s2_y", y, 32'h0002_0000);
    check("s2_w", w_q, 32'hFFFF_8000);
    check("s2_ovf", 32'(ovf_sticky), 32'd0);
    release_y();

    // x=1.0 with w=-0.5: wn=1.25, y=2.5-1.5; held 10 cycles
    send(32'h0001_0000);
    @(negedge clk);
    x = 32'h1234_5678;
    x_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("hold_y", y, 32'h0001_0000);
      check("hold_yv", 32'(y_valid), 32'd1);
      check("hold_w", w_q, 32'h0001_4000);
      check("hold_xr", 32'(x_ready), 32'd0);
    end
    release_y();
    @(posedge clk);
    #1 check("after_rel_busy", 32'(busy), 32'd0);

    // clear during MB0 aborts the sample
    @(negedge clk);
    x = 32'h0002_0000;
    x_valid = 1'b1;
    @(posedge clk);
    #1 x_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    pulse_clear();
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_w", w_q, 32'h0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 check("clr_no_yv", 32'(y_valid), 32'd0);
    end
    send(32'h0001_0000);
    check("clr_s_y", y, 32'h0002_0000);
    check("clr_s_w", w_q, 32'h0001_0000);
    release_y();

    // Adder overflow on the W0=0x8000_0000 instance
    pulse_clear();
    check("ovf_pre", 32'(ovf_sticky2), 32'd0);
    check("ovf_pre_w", w_q2, 32'h8000_0000);
`ifdef IIR1_SAT_EN
    w_exp2 = 32'h7FFF_FFFF;
`else
    w_exp2 = 32'hBFFF_0000;
`endif
    send(32'h7FFF_0000);
    check("ovf_yv2", 32'(y_valid2), 32'd1);
    check("ovf_set", 32'(ovf_sticky2), 32'd1);
    check("ovf_w2", w_q2, w_exp2);
    check("mulovf_ign", 32'(ovf_sticky), 32'd0);
    check("nonovf_w", w_q, 32'h7FFF_0000);
    release_y();
    pulse_clear();
    check("ovf_clr", 32'(ovf_sticky2), 32'd0);
    check("ovf_clr_w", w_q2, 32'h8000_0000);

    // Asynchronous reset while holding a result
    send(32'h0001_0000);
    check("pre_rst_y", y, 32'h0002_0000);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_yv", 32'(y_valid), 32'd0);
    check("arst_y", y, 32'h0);
    check("arst_w", w_q, 32'h0);
    check("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("arst_xr", 32'(x_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
